// File: rtl/imem_banked.sv
// imem_banked: byte-enabled, little-endian instruction store with a registered fetch port, a load port and a post-reset clear FSM
module imem_banked #(
  parameter int          DEPTH_BYTES    = 256,
  parameter int          ADDR_W         = 32,
  parameter logic [31:0] FILL_WORD      = 32'h00000013,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              im_req,
  input  logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_inst,
  output logic              im_valid,
  output logic              im_fault,
  output logic              im_busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       inst,
  input  logic [3:0]        ld_be,
  output logic              ld_ready,
  output logic              ld_err
);
  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int CW = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH_BYTES - 4);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic valid_q, valid_d, fault_q, fault_d, err_q, err_d;
  logic [3:0][7:0] mem_q [WORDS];
  logic im_ok, ld_ok, ld_acc;
  logic [CW-1:0] im_idx, ld_idx;
  // full-width compare so high address bits can never alias into the array
  assign im_ok = (im_addr[1:0] == 2'b00) && (im_addr <= LAST);
  assign ld_ok = (ld_addr[1:0] == 2'b00) && (ld_addr <= LAST);
  assign im_idx = im_addr[CW+1:2];
  assign ld_idx = ld_addr[CW+1:2];
  assign ld_acc = ld_en && (state_q == READY);
  assign im_busy = (state_q == CLEAR);
  assign ld_ready = (state_q == READY);
  assign im_inst = inst_q;
  assign im_valid = valid_q;
  assign im_fault = fault_q;
  assign ld_err = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    inst_d = inst_q;
    valid_d = 1'b0;
    fault_d = fault_q;
    err_d = ld_acc && !ld_ok;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(WORDS - 1)) ? READY : CLEAR;
    end else if (im_req) begin
      valid_d = 1'b1;
      fault_d = !im_ok;
      inst_d = im_ok ? mem_q[im_idx] : FILL_WORD;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : READY;
      cnt_q <= '0;
      inst_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      inst_q <= inst_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      err_q <= err_d;
    end
  end
  // array is not reset; nonblocking writes give read-before-write on a same-edge fetch
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem_q[cnt_q] <= FILL_WORD;
    else if (ld_acc && ld_ok)
      for (int k = 0; k < 4; k++)
        if (ld_be[k]) mem_q[ld_idx][k] <= inst[8*k +: 8];
  end
endmodule
